apb_master_n: RTL and testbench

- Parametrised successor to the fixed 11-slot APB master used by the MCU top.
- Bridges the RV32I core's single-cycle data-bus request to an APB3 bus with NUM_SLAVES select lines.
- Decodes slots by address arithmetic rather than a hard-coded case list.
- Adds PSLVERR propagation, decode-error reporting and a programmable PREADY timeout, so a hung or missing peripheral cannot stall the core.

---
 rtl/apb_master_n.sv | 163 ++++++++++++++++
 tb/tb_apb_master_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_n.sv
// apb_master_n: bridges the core's single-cycle data-bus request to an APB3 bus
// with NUM_SLAVES select lines. Slots are decoded by address arithmetic. The
// completion response reports a slave error, a decode miss or a PREADY timeout
// so that a hung or absent peripheral cannot stall the core.
//
// Ports:
//   PCLK, PRESET          clock (rising edge), asynchronous active-high reset
//   transfer, write       request strobe and direction from the core
//   addr, wdata           request byte address and write data
//   rdata, ready, error   completion pulse, read data and error qualifier
//   PADDR, PWDATA         APB address and write data
//   PWRITE, PENABLE, PSEL APB direction, enable and one-hot slave select
//   PRDATA, PREADY        flattened per-slot read data and per-slot ready
//   PSLVERR               per-slot error
module apb_master_n #(
    parameter int unsigned       NUM_SLAVES = 11,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000_0000,
    parameter int unsigned       SLOT_SHIFT = 12,
    parameter int unsigned       TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         error,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       paddr_q;
    logic [DATA_W-1:0]       pwdata_q;
    logic                    pwrite_q;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    load;
    logic [ADDR_W-1:0]       off;
    logic [ADDR_W-1:0]       slot_idx;
    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    hit;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;
    logic                    tmo;

    assign load   = (state_q == IDLE) && transfer;
    assign hit    = |sel_q;
    assign tmo    = TMO_EN && (cnt_q == CNT_LAST);
    assign PADDR  = paddr_q;
    assign PWDATA = pwdata_q;
    assign PWRITE = pwrite_q;

    // Address decode; the select is stored one-hot so a miss is simply all zeros.
    always_comb begin
        off      = addr - BASE_ADDR;
        slot_idx = off >> SLOT_SHIFT;
        dec_hit  = (addr >= BASE_ADDR) && (slot_idx < ADDR_W'(NUM_SLAVES));
        dec_sel  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            dec_sel[i] = dec_hit && (slot_idx == ADDR_W'(i));
        end
    end

    // Only the selected slot's response is looked at; others are masked out.
    always_comb begin
        sel_ready = |(PREADY & sel_q);
        sel_err   = |(PSLVERR & sel_q);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                paddr_q  <= addr;
                pwdata_q <= wdata;
                pwrite_q <= write;
                sel_q    <= dec_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (!hit || sel_ready || tmo) begin
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // PREADY is tested before the timeout so a same-cycle ready completes cleanly.
    always_comb begin
        PSEL    = (state_q != IDLE) ? sel_q : '0;
        PENABLE = (state_q == ACCESS);
        ready   = 1'b0;
        error   = 1'b0;
        rdata   = '0;
        if (state_q == ACCESS) begin
            if (!hit) begin
                ready = 1'b1;
                error = 1'b1;
            end else if (sel_ready) begin
                ready = 1'b1;
                error = sel_err;
                rdata = pwrite_q ? '0 : sel_rdata;
            end else if (tmo) begin
                ready = 1'b1;
                error = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_n.sv
module tb_apb_master_n;

    localparam int unsigned NS   = 11;
    localparam int unsigned TMO  = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic           PCLK;
    logic           PRESET;
    logic           transfer;
    logic           write;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic           ready;
    logic           error;
    logic [31:0]    PADDR;
    logic [31:0]    PWDATA;
    logic           PWRITE;
    logic           PENABLE;
    logic [NS-1:0]  PSEL;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  PSLVERR;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    apb_master_n #(
        .NUM_SLAVES (NS),
        .ADDR_W     (32),
        .DATA_W     (32),
        .BASE_ADDR  (BASE),
        .SLOT_SHIFT (12),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_bus();
        PREADY  = NS'($urandom);
        PSLVERR = NS'($urandom);
        for (int i = 0; i < NS; i++) PRDATA[i*32 +: 32] = $urandom;
    endtask

    // One request, called just after a rising edge with the DUT idle.
    // d = number of ACCESS cycles the target slot keeps PREADY low.
    // stray = also pulse transfer during SETUP (must be ignored).
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned d, input logic serr, input logic [31:0] rd,
                           input logic stray);
        logic          hit;
        int unsigned   slot;
        int unsigned   lat;
        logic          exp_err;
        logic [31:0]   exp_rd;
        logic [NS-1:0] exp_sel;
        logic [NS-1:0] one;

        one  = 1;
        hit  = 1'b0;
        slot = 0;
        if (a >= BASE) begin
            slot = (a - BASE) / 4096;
            hit  = (slot < NS);
        end
        if (!hit) begin
            lat = 2; exp_err = 1'b1; exp_rd = 0; exp_sel = '0;
        end else begin
            exp_sel = one << slot;
            if (d < TMO) begin
                lat = 2 + d; exp_err = serr; exp_rd = wr ? 32'd0 : rd;
            end else begin
                lat = 1 + TMO; exp_err = 1'b1; exp_rd = 0;
            end
        end

        for (int unsigned c = 0; c <= lat + 1; c++) begin
            transfer = (c == 0) || (stray && c == 1);
            if (c == 0) begin
                write = wr; addr = a; wdata = wd;
            end else if (c == 1 && stray) begin
                write = ~wr; addr = $urandom; wdata = $urandom;
            end
            randomize_bus();
            if (hit) begin
                PREADY[slot]          = (c >= 2 + d);
                PSLVERR[slot]         = serr;
                PRDATA[slot*32 +: 32] = rd;
            end
            @(negedge PCLK);
            check("psel", 64'(PSEL), (c >= 1 && c <= lat) ? 64'(exp_sel) : 64'd0);
            check("penable", 64'(PENABLE), 64'(c >= 2 && c <= lat));
            check("ready", 64'(ready), 64'(c == lat));
            if (c == lat) begin
                check("error", 64'(error), 64'(exp_err));
                check("rdata", 64'(rdata), 64'(exp_rd));
            end else begin
                check("error_idle", 64'(error), 64'd0);
                check("rdata_idle", 64'(rdata), 64'd0);
            end
            if (c >= 1) begin
                check("paddr", 64'(PADDR), 64'(a));
                check("pwdata", 64'(PWDATA), 64'(wd));
                check("pwrite", 64'(PWRITE), 64'(wr));
            end
            @(posedge PCLK); #1;
        end
        transfer = 1'b0;
    endtask

    initial begin
        PRESET   = 1'b1;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        PRDATA   = '0;
        PREADY   = '0;
        PSLVERR  = '0;

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Directed cases from the plan, plus decode edges.
        do_xfer(1'b1, 32'h1000_1004, 32'h0000_00A5, 0, 1'b0, 32'h1111_1111, 1'b0);
        do_xfer(1'b0, 32'h1000_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_xfer(1'b0, 32'h1000_B000, 32'h0,         0, 1'b0, 32'h2222_2222, 1'b0);
        do_xfer(1'b0, 32'h0FFF_FFFC, 32'h0,         0, 1'b0, 32'h3333_3333, 1'b0);
        do_xfer(1'b0, 32'h1000_3000, 32'h0,        20, 1'b0, 32'h4444_4444, 1'b0);
        do_xfer(1'b0, 32'h1000_3008, 32'h0,         7, 1'b0, 32'h5555_AAAA, 1'b0);
        do_xfer(1'b0, 32'h1000_5000, 32'h0,         0, 1'b1, 32'h6666_6666, 1'b0);
        do_xfer(1'b0, 32'h1000_5000, 32'h0,         0, 1'b0, 32'h7777_7777, 1'b0);
        do_xfer(1'b1, 32'h1000_AFFF, 32'hCAFE_0001, 1, 1'b0, 32'h0,         1'b1);
        do_xfer(1'b0, 32'h0FFF_FFFF, 32'h0,         0, 1'b0, 32'h8888_8888, 1'b1);
        do_xfer(1'b0, 32'h1000_0000, 32'h0,         2, 1'b0, 32'h1234_5678, 1'b1);

        // Randomized traffic: hits, misses above the window, misses below base.
        for (int n = 0; n < 80; n++) begin
            int unsigned cat;
            logic [31:0] a;
            logic [31:0] ofs;
            cat = $urandom_range(0, 9);
            ofs = 32'($urandom_range(0, 4095));
            if (cat == 0) begin
                a = 32'($urandom_range(0, 32'h0FFF_FFFF));
            end else if (cat == 1) begin
                a = BASE + (32'($urandom_range(11, 4000)) << 12) + ofs;
            end else begin
                a = BASE + (32'($urandom_range(0, NS - 1)) << 12) + ofs;
            end
            do_xfer(1'($urandom), a, $urandom, $urandom_range(0, 11),
                    ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
        end

        // Asynchronous reset in the middle of an ACCESS phase.
        transfer = 1'b1; write = 1'b0; addr = BASE + 32'h3000; wdata = 32'h0;
        PREADY = '0; PSLVERR = '0;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("pre_rst_penable", 64'(PENABLE), 64'd1);
        check("pre_rst_psel", 64'(PSEL), 64'h8);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_psel", 64'(PSEL), 64'd0);
        check("async_penable", 64'(PENABLE), 64'd0);
        check("async_ready", 64'(ready), 64'd0);
        check("async_paddr", 64'(PADDR), 64'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        do_xfer(1'b0, 32'h1000_2040, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
